clk_div_prog: RTL and testbench
===============================

CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 The module SHALL have parameter W, default 8, giving the divisor and phase-counter width in bits.
REQ-002 The module SHALL have parameter DEFAULT_DIV, default 4, giving the divisor loaded at reset (legal range 1..2^W-1).
REQ-003 The module SHALL have port clk_in, input, 1 bit: the single clock; all registers update on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The module SHALL have port en, input, 1 bit: divider run enable.
REQ-006 The module SHALL have port load, input, 1 bit: strobe that captures div_val.
REQ-007 The module SHALL have port div_val, input, W bits: requested divisor N.
REQ-008 The module SHALL have port clk_out, output, 1 bit: divided clock, registered.
REQ-009 The module SHALL have port tick, output, 1 bit: one-cycle pulse marking each period start, registered.
REQ-010 The module SHALL have port pending, output, 1 bit: a captured divisor is waiting to be applied.
REQ-011 The module SHALL have port cur_div, output, W bits: the divisor governing the current period.

Function
REQ-012 The active divisor SHALL be N = cur_div; the high time SHALL be H = (N+1)>>1 cycles, computed without overflow, and the low time SHALL be N-H cycles.
REQ-013 Let k be the count of consecutive enabled edges since the current period began (k=0 at the period-start edge); after each enabled edge the module SHALL drive clk_out=1 iff k<H, and tick=1 iff k=0.
REQ-014 Consequences of REQ-013: even N gives exactly 50% duty; odd N gives a high phase one cycle longer than the low phase; the output period SHALL be exactly N clk_in cycles.
REQ-015 When N=1, clk_out SHALL stay 1 and tick SHALL be 1 on every enabled edge.
REQ-016 A div_val of 0 SHALL be treated as 1 wherever it is captured; cur_div SHALL never read 0.
REQ-017 The edge on which load=1 SHALL copy div_val into a shadow register and set pending=1.
REQ-018 When load repeats before the shadow value is applied, the latest div_val SHALL win.
REQ-019 The shadow value SHALL be applied to cur_div only on a period-start edge (k wraps to 0, or first enabled edge after en rises); pending SHALL clear on that same edge.
REQ-020 When load=1 coincides with a period-start edge, the div_val presented on that edge SHALL govern the period starting on that edge, and pending SHALL read 0 afterwards.
REQ-021 A period SHALL never be truncated or stretched by load: the period in progress always completes with its original N.
REQ-022 When en=0 on an edge, the phase counter SHALL go to its idle state, with clk_out=0 and tick=0 after that edge; load SHALL still be honoured.
REQ-023 The first enabled edge after en rises SHALL start a fresh period (k=0, tick=1, clk_out=1), applying any pending divisor.
REQ-024 en dropping mid-period SHALL abandon that period without completing it.
REQ-025 When rst_n=0 and load=1 on the same edge, rst_n SHALL take priority.

Reset
REQ-026 On an edge with rst_n=0, the module SHALL set clk_out=0, tick=0, pending=0, cur_div=DEFAULT_DIV (0 mapped to 1), shadow register=DEFAULT_DIV, and the phase counter to idle.
REQ-027 Reset SHALL take priority over en and load.
REQ-028 A reset asserted mid-period SHALL abandon that period.
REQ-029 The first enabled edge after rst_n returns high SHALL behave as REQ-023.

Verification
REQ-030 The bench SHALL cover reset then en=1 with defaults (W=8, DEFAULT_DIV=4) -> clk_out pattern 1,1,0,0 repeating, tick on cycles 0,4,8,...
REQ-031 The bench SHALL cover a load of div_val=5 at period cycle k=1 -> current 4-cycle period completes, then 1,1,1,0,0 repeating, pending high from the load edge until the next tick.
REQ-032 The bench SHALL cover a load of div_val=0, then div_val=1 -> cur_div=1, clk_out constant 1, tick every cycle; div_val=0 captured alone likewise yields cur_div=1.
REQ-033 The bench SHALL cover a load of 3 on the same edge as a period-start tick, with N=6 -> that period is already 1,1,0, pending=0.
REQ-034 The bench SHALL cover en dropped at k=2 of N=7, a load of 2, then en re-raised -> clk_out=0 while disabled, restart with tick=1 and pattern 1,0 repeating.
REQ-035 The bench SHALL cover rst_n=0 asserted mid-period with pending=1 -> next edge clk_out=0, tick=0, pending=0, cur_div=4.

Source files
------------

// File: rtl/clk_div_prog.sv
// -----------------------------------------------------------------------------
// clk_div_prog -- programmable integer clock divider with glitch-free reload.
//
// Divides clk_in by N = cur_div. Each output period is exactly N input cycles:
// clk_out is high for H = ceil(N/2) cycles, then low for N-H cycles. tick
// pulses for one cycle at every period start. A new divisor captured with
// load is held in a shadow register and only takes effect on a period-start
// edge, so a period in progress is never cut short or stretched.
//
// Parameters
//   W           : divisor / phase-counter width in bits
//   DEFAULT_DIV : divisor loaded at reset (0 is treated as 1)
//
// Ports
//   clk_in   in  : clock, all registers update on its rising edge
//   rst_n    in  : synchronous active-low reset
//   en       in  : run enable; low forces the divider idle (clk_out=0)
//   load     in  : strobe capturing div_val into the shadow register
//   div_val  in  : requested divisor N (0 is treated as 1)
//   clk_out  out : divided clock, registered
//   tick     out : one-cycle pulse on each period start, registered
//   pending  out : a captured divisor is waiting for the next period start
//   cur_div  out : divisor governing the current period (never 0)
// -----------------------------------------------------------------------------
module clk_div_prog #(
    parameter int W           = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] div_val,
    output logic         clk_out,
    output logic         tick,
    output logic         pending,
    output logic [W-1:0] cur_div
);

    localparam logic [W-1:0] DEF_W   = W'(DEFAULT_DIV);
    localparam logic [W-1:0] RST_DIV = (DEF_W == '0) ? W'(1) : DEF_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   k_cnt, k_nxt;
    logic [W-1:0]   shadow_div, shadow_nxt;
    logic [W-1:0]   cur_nxt;
    logic           pend_nxt;
    logic           clk_nxt;
    logic           tick_nxt;
    logic           period_start;
    logic [W-1:0]   new_div;

    // A zero divisor is meaningless; clamp it to 1 wherever it is captured.
    function automatic logic [W-1:0] sat_div(input logic [W-1:0] v);
        return (v == '0) ? W'(1) : v;
    endfunction

    // ceil(n/2) without widening: (n>>1) + lsb cannot overflow W bits.
    function automatic logic [W-1:0] high_time(input logic [W-1:0] n);
        return (n >> 1) + {{(W-1){1'b0}}, n[0]};
    endfunction

    always_comb begin
        state_nxt    = state;
        k_nxt        = k_cnt;
        shadow_nxt   = shadow_div;
        cur_nxt      = cur_div;
        pend_nxt     = pending;
        clk_nxt      = clk_out;
        tick_nxt     = 1'b0;
        period_start = 1'b0;
        new_div      = cur_div;

        if (!en) begin
            // Disabled: abandon any period; loads are still captured.
            state_nxt = ST_IDLE;
            k_nxt     = '0;
            clk_nxt   = 1'b0;
            if (load) begin
                shadow_nxt = sat_div(div_val);
                pend_nxt   = 1'b1;
            end
        end else begin
            // A period starts on the first enabled edge out of idle, or when
            // the previous period has just spent its last (N-th) cycle.
            period_start = (state == ST_IDLE) || (k_cnt == cur_div - W'(1));
            if (period_start) begin
                // A load on this very edge overrides any older shadow value.
                if (load) begin
                    new_div    = sat_div(div_val);
                    shadow_nxt = sat_div(div_val);
                end else if (pending) begin
                    new_div = shadow_div;
                end
                cur_nxt   = new_div;
                pend_nxt  = 1'b0;
                state_nxt = ST_RUN;
                k_nxt     = '0;
                clk_nxt   = 1'b1;   // H >= 1 for every legal N
                tick_nxt  = 1'b1;
            end else begin
                // k_cnt <= N-2 here, so k_cnt+1 stays within W bits.
                k_nxt   = k_cnt + W'(1);
                clk_nxt = (k_cnt + W'(1)) < high_time(cur_div);
                if (load) begin
                    shadow_nxt = sat_div(div_val);
                    pend_nxt   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            k_cnt      <= '0;
            shadow_div <= RST_DIV;
            cur_div    <= RST_DIV;
            pending    <= 1'b0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
        end else begin
            state      <= state_nxt;
            k_cnt      <= k_nxt;
            shadow_div <= shadow_nxt;
            cur_div    <= cur_nxt;
            pending    <= pend_nxt;
            clk_out    <= clk_nxt;
            tick       <= tick_nxt;
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// -----------------------------------------------------------------------------
// tb_clk_div_prog -- scoreboard bench for clk_div_prog (W=8, DEFAULT_DIV=4).
// Stimulus drives inputs on the falling edge and pushes the hand-computed
// outputs expected after the next rising edge; the monitor pops and compares
// shortly after each rising edge.
// -----------------------------------------------------------------------------
module tb_clk_div_prog;

    logic       clk_in;
    logic       rst_n;
    logic       en;
    logic       load;
    logic [7:0] div_val;
    logic       clk_out;
    logic       tick;
    logic       pending;
    logic [7:0] cur_div;

    clk_div_prog #(.W(8), .DEFAULT_DIV(4)) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .en      (en),
        .load    (load),
        .div_val (div_val),
        .clk_out (clk_out),
        .tick    (tick),
        .pending (pending),
        .cur_div (cur_div)
    );

    typedef struct {
        int         id;
        logic       c;
        logic       t;
        logic       p;
        logic [7:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   vec_id   = 0;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // One edge of stimulus: inputs (r=rst_n, e=en, l=load, dv) and the
    // outputs expected after that edge (clk_out, tick, pending, cur_div).
    task automatic step(input logic r, input logic e, input logic l,
                        input logic [7:0] dv,
                        input logic ec, input logic et, input logic ep,
                        input logic [7:0] ed);
        exp_t x;
        @(negedge clk_in);
        rst_n   = r;
        en      = e;
        load    = l;
        div_val = dv;
        x.id = vec_id;
        x.c  = ec;
        x.t  = et;
        x.p  = ep;
        x.d  = ed;
        exp_q.push_back(x);
        vec_id++;
    endtask

    // Monitor: every rising edge yields one output sample to check.
    always @(posedge clk_in) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t x;
            x = exp_q.pop_front();
            checks++;
            if (clk_out !== x.c || tick !== x.t || pending !== x.p || cur_div !== x.d) begin
                failures++;
                $display("FAIL vec%0d: got clk_out=%b tick=%b pending=%b cur_div=%0d, want clk_out=%b tick=%b pending=%b cur_div=%0d",
                         x.id, clk_out, tick, pending, cur_div, x.c, x.t, x.p, x.d);
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        load    = 1'b0;
        div_val = 8'd0;

        // Reset has priority over en and load.
        step(0, 1, 1, 8'd9,  0, 0, 0, 8'd4);
        step(0, 0, 0, 8'd0,  0, 0, 0, 8'd4);

        // Defaults N=4: 1,1,0,0 repeating, tick every 4.
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 0, 8'd0,  1, 1, 0, 8'd4);
            step(1, 1, 0, 8'd0,  1, 0, 0, 8'd4);
            step(1, 1, 0, 8'd0,  0, 0, 0, 8'd4);
            step(1, 1, 0, 8'd0,  0, 0, 0, 8'd4);
        end

        // Load 5 at k=1: the N=4 period completes, then 1,1,1,0,0.
        step(1, 1, 0, 8'd0,  1, 1, 0, 8'd4);
        step(1, 1, 1, 8'd5,  1, 0, 1, 8'd4);
        step(1, 1, 0, 8'd0,  0, 0, 1, 8'd4);
        step(1, 1, 0, 8'd0,  0, 0, 1, 8'd4);
        step(1, 1, 0, 8'd0,  1, 1, 0, 8'd5);
        step(1, 1, 0, 8'd0,  1, 0, 0, 8'd5);
        step(1, 1, 0, 8'd0,  1, 0, 0, 8'd5);
        step(1, 1, 0, 8'd0,  0, 0, 0, 8'd5);
        step(1, 1, 0, 8'd0,  0, 0, 0, 8'd5);
        step(1, 1, 0, 8'd0,  1, 1, 0, 8'd5);

        // Load 0 then 1 before application: latest wins, N=1.
        step(1, 1, 1, 8'd0,  1, 0, 1, 8'd5);
        step(1, 1, 1, 8'd1,  1, 0, 1, 8'd5);
        step(1, 1, 0, 8'd0,  0, 0, 1, 8'd5);
        step(1, 1, 0, 8'd0,  0, 0, 1, 8'd5);
        for (int i = 0; i < 4; i++)
            step(1, 1, 0, 8'd0,  1, 1, 0, 8'd1);

        // Load 6 on an N=1 edge applies immediately.
        step(1, 1, 1, 8'd6,  1, 1, 0, 8'd6);
        step(1, 1, 0, 8'd0,  1, 0, 0, 8'd6);
        step(1, 1, 0, 8'd0,  1, 0, 0, 8'd6);
        step(1, 1, 0, 8'd0,  0, 0, 0, 8'd6);
        step(1, 1, 0, 8'd0,  0, 0, 0, 8'd6);
        step(1, 1, 0, 8'd0,  0, 0, 0, 8'd6);
        // Load 3 on the period-start edge: that period is already 1,1,0.
        step(1, 1, 1, 8'd3,  1, 1, 0, 8'd3);
        step(1, 1, 0, 8'd0,  1, 0, 0, 8'd3);
        step(1, 1, 0, 8'd0,  0, 0, 0, 8'd3);
        step(1, 1, 0, 8'd0,  1, 1, 0, 8'd3);
        // div_val=0 captured alone becomes 1.
        step(1, 1, 1, 8'd0,  1, 0, 1, 8'd3);
        step(1, 1, 0, 8'd0,  0, 0, 1, 8'd3);
        step(1, 1, 0, 8'd0,  1, 1, 0, 8'd1);
        step(1, 1, 0, 8'd0,  1, 1, 0, 8'd1);

        // N=7, drop en after k=2, load 2 while idle, re-enable.
        step(1, 1, 1, 8'd7,  1, 1, 0, 8'd7);
        step(1, 1, 0, 8'd0,  1, 0, 0, 8'd7);
        step(1, 1, 0, 8'd0,  1, 0, 0, 8'd7);
        step(1, 0, 0, 8'd0,  0, 0, 0, 8'd7);
        step(1, 0, 1, 8'd2,  0, 0, 1, 8'd7);
        step(1, 0, 0, 8'd0,  0, 0, 1, 8'd7);
        step(1, 1, 0, 8'd0,  1, 1, 0, 8'd2);
        step(1, 1, 0, 8'd0,  0, 0, 0, 8'd2);
        step(1, 1, 0, 8'd0,  1, 1, 0, 8'd2);
        step(1, 1, 0, 8'd0,  0, 0, 0, 8'd2);
        step(1, 1, 0, 8'd0,  1, 1, 0, 8'd2);

        // Reset mid-period with pending=1 (and a competing load).
        step(1, 1, 1, 8'd5,  0, 0, 1, 8'd2);
        step(0, 1, 1, 8'd9,  0, 0, 0, 8'd4);
        step(1, 0, 0, 8'd0,  0, 0, 0, 8'd4);
        step(1, 1, 0, 8'd0,  1, 1, 0, 8'd4);
        step(1, 1, 0, 8'd0,  1, 0, 0, 8'd4);
        step(1, 1, 0, 8'd0,  0, 0, 0, 8'd4);
        step(1, 1, 0, 8'd0,  0, 0, 0, 8'd4);
        step(1, 1, 0, 8'd0,  1, 1, 0, 8'd4);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && exp_q.size() != 0; i++)
            @(posedge clk_in);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
